// File: rtl/axi_addr_arb3.sv
// axi_addr_arb3: 3-to-1 AXI address-channel arbiter (fixed / round-robin / weighted) with a registered output stage.
// Define AXI_ARB_STATS_EN to add grant and stall counters with stat_clr.
module axi_addr_arb3 #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arb_en,
  input  logic [1:0]        arb_mode,
  input  logic [15:0]       weight0,
  input  logic [15:0]       weight1,
  input  logic [15:0]       weight2,
  input  logic [2:0]        s_valid,
  output logic [2:0]        s_ready,
  input  logic [ADDR_W-1:0] s_addr0,
  input  logic [ADDR_W-1:0] s_addr1,
  input  logic [ADDR_W-1:0] s_addr2,
  input  logic [ID_W-1:0]   s_id0,
  input  logic [ID_W-1:0]   s_id1,
  input  logic [ID_W-1:0]   s_id2,
  input  logic [LEN_W-1:0]  s_len0,
  input  logic [LEN_W-1:0]  s_len1,
  input  logic [LEN_W-1:0]  s_len2,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [ID_W-1:0]   m_id,
  output logic [LEN_W-1:0]  m_len,
  output logic [1:0]        m_src
`ifdef AXI_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1,
  output logic [31:0]       grant_cnt2,
  output logic [31:0]       stall_cnt
`endif
);
  logic              m_valid_q, m_valid_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [ID_W-1:0]   m_id_q, m_id_d;
  logic [LEN_W-1:0]  m_len_q, m_len_d;
  logic [1:0]        m_src_q, m_src_d;
  logic [1:0]        last_q, last_d;
  logic [16:0]       cnt_q, cnt_d;
  logic [2:0]        cfg_q, cfg_d;
  logic [2:0]        elig;
  logic [1:0]        nxt1, nxt2, rr_w, prio_w, w;
  logic [15:0]       wt_last;
  logic              hold, free, grant, cfg_chg;
  always_comb begin
    elig     = arb_en ? s_valid : {2'b00, s_valid[0]};
    nxt1     = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    nxt2     = (nxt1 == 2'd2) ? 2'd0 : nxt1 + 2'd1;
    rr_w     = elig[nxt1] ? nxt1 : elig[nxt2] ? nxt2 : last_q;
    prio_w   = elig[0] ? 2'd0 : elig[1] ? 2'd1 : 2'd2;
    wt_last  = (last_q == 2'd0) ? weight0 : (last_q == 2'd1) ? weight1 : weight2;
    // cnt==0 means no streak yet, so a fresh start always goes through rotation
    hold     = elig[last_q] && (cnt_q != 17'd0) && (cnt_q <= {1'b0, wt_last});
    w        = (arb_mode == 2'd1) ? rr_w : (arb_mode == 2'd2) ? (hold ? last_q : rr_w) : prio_w;
    free     = !m_valid_q || m_ready;
    grant    = free && (elig != 3'b000);
    s_ready  = grant ? (3'b001 << w) : 3'b000;
    m_valid_d = grant ? 1'b1 : m_ready ? 1'b0 : m_valid_q;
    m_addr_d = !grant ? m_addr_q : (w == 2'd0) ? s_addr0 : (w == 2'd1) ? s_addr1 : s_addr2;
    m_id_d   = !grant ? m_id_q : (w == 2'd0) ? s_id0 : (w == 2'd1) ? s_id1 : s_id2;
    m_len_d  = !grant ? m_len_q : (w == 2'd0) ? s_len0 : (w == 2'd1) ? s_len1 : s_len2;
    m_src_d  = grant ? w : m_src_q;
    cfg_d    = {arb_en, arb_mode};
    cfg_chg  = cfg_d != cfg_q;
    cnt_d    = cfg_chg ? 17'd0 : !grant ? cnt_q : (w != last_q) ? 17'd1 : (&cnt_q) ? cnt_q : cnt_q + 17'd1;
    last_d   = grant ? w : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_id_q    <= '0;
      m_len_q   <= '0;
      m_src_q   <= 2'd0;
      last_q    <= 2'd2;
      cnt_q     <= 17'd0;
      cfg_q     <= 3'd0;
    end else begin
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_id_q    <= m_id_d;
      m_len_q   <= m_len_d;
      m_src_q   <= m_src_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
    end
  end
  assign m_valid = m_valid_q;
  assign m_addr  = m_addr_q;
  assign m_id    = m_id_q;
  assign m_len   = m_len_q;
  assign m_src   = m_src_q;
`ifdef AXI_ARB_STATS_EN
  logic [31:0] g0_q, g0_d, g1_q, g1_d, g2_q, g2_d, st_q, st_d;
  always_comb begin
    g0_d = stat_clr ? 32'd0 : g0_q + {31'd0, s_valid[0] && s_ready[0]};
    g1_d = stat_clr ? 32'd0 : g1_q + {31'd0, s_valid[1] && s_ready[1]};
    g2_d = stat_clr ? 32'd0 : g2_q + {31'd0, s_valid[2] && s_ready[2]};
    st_d = stat_clr ? 32'd0 : st_q + {31'd0, m_valid_q && !m_ready};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g0_q <= 32'd0;
      g1_q <= 32'd0;
      g2_q <= 32'd0;
      st_q <= 32'd0;
    end else begin
      g0_q <= g0_d;
      g1_q <= g1_d;
      g2_q <= g2_d;
      st_q <= st_d;
    end
  end
  assign grant_cnt0 = g0_q;
  assign grant_cnt1 = g1_q;
  assign grant_cnt2 = g2_q;
  assign stall_cnt  = st_q;
`endif
endmodule

// File: tb/tb_axi_addr_arb3.sv
// tb_axi_addr_arb3: random and directed stimulus checked every cycle against a behavioural arbiter model.
module tb_axi_addr_arb3;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arb_en = 1'b0;
  logic [1:0]  arb_mode = 2'd0;
  logic [15:0] weight0 = 16'd0, weight1 = 16'd0, weight2 = 16'd0;
  logic [2:0]  s_valid = 3'b000;
  logic [2:0]  s_ready;
  logic [31:0] s_addr0 = 32'h0, s_addr1 = 32'h100, s_addr2 = 32'h200;
  logic [3:0]  s_id0 = 4'd0, s_id1 = 4'd1, s_id2 = 4'd2;
  logic [7:0]  s_len0 = 8'd0, s_len1 = 8'd1, s_len2 = 8'd2;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_addr;
  logic [3:0]  m_id;
  logic [7:0]  m_len;
  logic [1:0]  m_src;
`ifdef AXI_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] grant_cnt0, grant_cnt1, grant_cnt2, stall_cnt;
`endif
  axi_addr_arb3 dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .arb_mode(arb_mode),
    .weight0(weight0), .weight1(weight1), .weight2(weight2),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_addr0(s_addr0), .s_addr1(s_addr1), .s_addr2(s_addr2),
    .s_id0(s_id0), .s_id1(s_id1), .s_id2(s_id2),
    .s_len0(s_len0), .s_len1(s_len1), .s_len2(s_len2),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_id(m_id),
    .m_len(m_len), .m_src(m_src)
`ifdef AXI_ARB_STATS_EN
    , .stat_clr(stat_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .grant_cnt2(grant_cnt2), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int q[$];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask
  function automatic int pick(input bit [2:0] el, input int mode, input int lst, input int c, input int wl);
    if (mode == 1 || mode == 2) begin
      if (mode == 2 && el[lst] && c > 0 && c <= wl) return lst;
      for (int k = 1; k <= 3; k++) if (el[(lst + k) % 3]) return (lst + k) % 3;
    end
    for (int k = 0; k < 3; k++) if (el[k]) return k;
    return 0;
  endfunction
  int m_last = 2, m_cnt = 0, m_w;
  bit m_mv = 0, m_gnt;
  bit [2:0] m_prev_cfg = 3'd0, m_el;
  logic [45:0] m_pay = '0;
  always @(negedge clk) begin
    logic [45:0] pays[3];
    int wts[3];
    if (!rst_n) begin
      m_last = 2; m_cnt = 0; m_mv = 0; m_pay = '0; m_prev_cfg = 3'd0;
      chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    end else begin
      pays[0] = {s_addr0, s_id0, s_len0, 2'd0};
      pays[1] = {s_addr1, s_id1, s_len1, 2'd1};
      pays[2] = {s_addr2, s_id2, s_len2, 2'd2};
      wts[0] = int'(weight0); wts[1] = int'(weight1); wts[2] = int'(weight2);
      m_el = arb_en ? s_valid : (s_valid & 3'b001);
      m_w = pick(m_el, int'(arb_mode), m_last, m_cnt, wts[m_last]);
      m_gnt = (!m_mv || m_ready) && (m_el != 3'b000);
      chk("s_ready", {61'd0, s_ready}, m_gnt ? 64'(1 << m_w) : 64'd0);
      chk("m_valid", {63'd0, m_valid}, {63'd0, m_mv});
      if (m_mv) chk("payload", {18'd0, m_addr, m_id, m_len, m_src}, {18'd0, m_pay});
      if (m_valid && m_ready) q.push_back(int'(m_src));
      if (m_gnt) begin
        m_mv = 1;
        m_pay = pays[m_w];
        m_cnt = (m_w == m_last) ? ((m_cnt + 1 > 131071) ? 131071 : m_cnt + 1) : 1;
        m_last = m_w;
      end else if (m_ready) m_mv = 0;
      if ({arb_en, arb_mode} != m_prev_cfg) m_cnt = 0;
      m_prev_cfg = {arb_en, arb_mode};
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input logic en, input logic [1:0] mode);
    @(posedge clk);
    #1 rst_n = 1'b0; s_valid = 3'b000; m_ready = 1'b0; arb_en = en; arb_mode = mode;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    q.delete();
  endtask
  task automatic check_q(input string n, input int n_exp, input int e[12]);
    chk({n, "_count"}, 64'(q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp; i++)
      if (i < q.size()) chk({n, "_src"}, 64'(q[i]), 64'(e[i]));
  endtask
  initial begin
    do_reset(1'b0, 2'd1);
    s_valid = 3'b111; m_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("en0_no_ready12", {62'd0, s_ready[2:1]}, 64'd0);
      @(posedge clk);
      #1;
    end
    s_valid = 3'b000; tick(3);
    check_q("en0", 10, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    do_reset(1'b1, 2'd0);
    s_valid = 3'b111; m_ready = 1'b1; tick(4);
    s_valid = 3'b110; tick(3);
    s_valid = 3'b100; tick(3);
    s_valid = 3'b000; tick(3);
    check_q("mode0", 10, '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0});
    do_reset(1'b1, 2'd1);
    s_valid = 3'b111; m_ready = 1'b1; tick(6);
    s_valid = 3'b000; tick(3);
    check_q("mode1", 6, '{0, 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0});
    weight0 = 16'd2; weight1 = 16'd0; weight2 = 16'd1;
    do_reset(1'b1, 2'd2);
    s_valid = 3'b111; m_ready = 1'b1; tick(12);
    s_valid = 3'b000; tick(3);
    check_q("mode2", 12, '{0, 0, 0, 1, 2, 2, 0, 0, 0, 1, 2, 2});
    do_reset(1'b1, 2'd0);
    s_addr0 = 32'h1000; s_id0 = 4'd3; s_valid = 3'b001; m_ready = 1'b0;
    tick(1);
    s_addr0 = 32'h2222; s_id0 = 4'd9;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, m_valid}, 64'd1);
      chk("stall_addr", {32'd0, m_addr}, 64'h1000);
      chk("stall_id", {60'd0, m_id}, 64'd3);
      chk("stall_ready", {61'd0, s_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    s_valid = 3'b000; m_ready = 1'b1; tick(2);
    do_reset(1'b1, 2'd1);
    s_valid = 3'b111; m_ready = 1'b1; tick(2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_rst_mvalid", {63'd0, m_valid}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    tick(3);
    s_valid = 3'b000; tick(3);
    check_q("post_rst", 3, '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    do_reset(1'b1, 2'd2);
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        arb_en = ($urandom_range(0, 4) != 0);
        arb_mode = 2'($urandom_range(0, 3));
        weight0 = 16'($urandom_range(0, 3));
        weight1 = 16'($urandom_range(0, 3));
        weight2 = 16'($urandom_range(0, 3));
      end
      s_valid = 3'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      s_addr0 = $urandom; s_addr1 = $urandom; s_addr2 = $urandom;
      s_id0 = 4'($urandom); s_id1 = 4'($urandom); s_id2 = 4'($urandom);
      s_len0 = 8'($urandom); s_len1 = 8'($urandom); s_len2 = 8'($urandom);
      tick(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_addr_arb3.md
Name: axi_addr_arb3

Overview:
- 3-to-1 arbiter for one AXI address channel (AW or AR); instantiate once per channel.
- Each upstream port is a valid/ready responder; the single downstream port is a registered valid/ready initiator.
- Arbitration policy comes from the ddr3 register block: arb_en, arb_mode, and per-channel weights.
- Grants must never violate the team's per-channel arbitration assertions.

Parameters:
- ADDR_W, 32, address width
- ID_W, 4, transaction ID width
- LEN_W, 8, burst length width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- arb_en  in  1  0: only channel 0 is serviced
- arb_mode  in  2  0 fixed priority, 1 round robin, 2 weighted round robin, 3 same as 0
- weight0/weight1/weight2  in  16 each  weighted-mode setting for each channel
- s_valid[2:0]  in  3  upstream valid, one bit per channel
- s_ready[2:0]  out  3  upstream ready, one-hot or zero
- s_addr0..2  in  ADDR_W each  upstream address
- s_id0..2  in  ID_W each  upstream ID
- s_len0..2  in  LEN_W each  upstream burst length
- m_valid  out  1  downstream valid
- m_ready  in  1  downstream ready
- m_addr  out  ADDR_W  downstream address
- m_id  out  ID_W  downstream ID
- m_len  out  LEN_W  downstream burst length
- m_src  out  2  winning channel index

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_addr/m_id/m_len/m_src=0, last=2, cnt=0. The reset value of last makes channel 0 first in rotation.
- Output register is free when m_valid=0 or when m_valid&&m_ready.
- Each cycle with the output register free, a winner w is picked from eligible s_valid bits.
- s_ready[w] is asserted combinationally that cycle. s_ready is 0 whenever the register is not free.
- At most one s_valid&&s_ready per cycle.
- On acceptance, payload is registered: m_valid=1 the next cycle, with m_src=w. Latency is 1 cycle.
- Sustained throughput is 1 per cycle when m_ready=1.
- m_valid stays high with a stable payload until m_ready.
- arb_en=0: only channel 0 is eligible. Channels 1 and 2 are never granted.
- Mode 0: priority 0>1>2.
- Mode 1: search order starts at last+1 mod 3. Never grants the same channel twice in a row while another channel is valid.
- Mode 2: cnt holds the consecutive grants to last (17-bit, saturating).
  - If s_valid[last] and cnt<=weight_last, last wins again.
  - Otherwise use the mode-1 rotation search.
  - Cap is weight_n+1 consecutive grants while others wait. weight=0 behaves like mode 1.
- cnt update per grant: cnt+1 if w==last, else 1. Then last=w.
- Sole requester: granted regardless of cnt. cnt keeps counting; the cap only applies when another channel is valid.
- Change to arb_en or arb_mode: cnt cleared the next cycle. An in-flight m_valid payload is unaffected.
- Upstream valid dropped before ready: no grant. Arbiter state is unchanged.
- Reset asserted mid-transfer: m_valid drops immediately (async). The pending payload is discarded.

Optional Feature:
- Macro: AXI_ARB_STATS_EN.
- Defined adds ports:
  - stat_clr in 1, synchronous
  - grant_cnt0/1/2 out 32 each, counting accepted handshakes per channel, wrapping at 2^32
  - stall_cnt out 32, counting cycles with m_valid&&!m_ready
- Counters reset to 0 by rst_n or stat_clr. stat_clr wins over a same-cycle increment.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical.

Test Plan:
- arb_en=0, all s_valid=1, m_ready=1 for 10 cycles -> 10 grants, all m_src=0; s_ready[1]/[2] never 1.
- Mode 0, all valid, m_ready=1 -> m_src=0 every cycle. Drop s_valid[0] -> m_src=1. Drop s_valid[1] too -> m_src=2.
- Mode 1, all valid continuously, m_ready=1 -> m_src sequence 0,1,2,0,1,2.
- Mode 2, weights 2/0/1, all valid -> m_src 0,0,0,1,2,2,0,0,0,1,2,2.
- m_ready held 0 for 5 cycles with payload 0x1000/id 3 -> m_valid, m_addr, m_id stable. s_ready=0 throughout, and no upstream handshake occurs.
- Async reset pulse while m_valid=1 -> m_valid=0 within the same cycle. After release, the first grant goes to channel 0 in mode 1.
